// File: rtl/cell_pos_pingpong_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cell_pos_pingpong_mem_pkg
// Description : Shared constants, FSM encoding and read-pipeline tag type
//               for the ping-pong cell position memory.
// Revision    : 1.0 - initial release
// ============================================================================
package cell_pos_pingpong_mem_pkg;

  localparam int c_axis_width     = 32;
  localparam int c_data_width_def = 3 * c_axis_width;  // {posz, posy, posx}
  localparam int c_read_latency   = 2;

  typedef logic [1:0] state_t;

  localparam state_t c_st_run   = 2'd0;
  localparam state_t c_st_drain = 2'd1;
  localparam state_t c_st_swap  = 2'd2;

  // Per-read sideband that travels alongside the RAM read.
  typedef struct packed {
    logic valid;
    logic zero;
    logic in_range;
    logic sel;
  } rd_tag_t;

endpackage
`default_nettype wire

// File: rtl/cell_pos_bank.sv
`default_nettype none
// ============================================================================
// Module      : cell_pos_bank
// Description : Single-port syncram bank with RAM output register
//               (two-cycle read latency) and optional init image.
// Revision    : 1.0 - initial release
// ============================================================================
module cell_pos_bank #(
  parameter int DATA_WIDTH = 96,
  parameter int DEPTH      = 220,
  parameter int ADDR_WIDTH = 8,
  parameter     INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] r_q1;

  // The init image is attached to the array so the vendor flow preloads it.
  if (INIT_FILE != "") begin : g_init
    (* ram_init_file = INIT_FILE *) logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we) begin
        r_mem[addr] <= wdata;
      end
      r_q1 <= r_mem[addr];
    end
  end else begin : g_noinit
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we) begin
        r_mem[addr] <= wdata;
      end
      r_q1 <= r_mem[addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= r_q1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cell_pos_pingpong_mem.sv
`default_nettype none
// ============================================================================
// Module      : cell_pos_pingpong_mem
// Description : Double-buffered cell position memory. Reads hit the active
//               bank, appends fill the shadow bank, swap exchanges roles after
//               the read pipeline drains. Optional macro
//               CELL_MEM_RANGE_CHECK_EN adds rd_oob and zeroes reads past
//               active_num.
// Revision    : 1.0 - initial release
// ============================================================================
module cell_pos_pingpong_mem
  import cell_pos_pingpong_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = c_data_width_def,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8,
  parameter     INIT_FILE    = "cell_ini.hex",
  parameter int INIT_NUM     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  swap_req,
  output logic                  swap_ack,
  output logic [ADDR_WIDTH-1:0] active_num,
  output logic [ADDR_WIDTH-1:0] shadow_num,
  output logic                  overflow
`ifdef CELL_MEM_RANGE_CHECK_EN
  ,
  output logic                  rd_oob
`endif
);

  localparam int c_lat = c_read_latency;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_bank_sel;
  logic [ADDR_WIDTH-1:0] r_active_num;
  logic [ADDR_WIDTH-1:0] r_shadow_num;
  logic                  r_overflow;

  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic                  w_shadow_full;
  logic                  w_wr_commit;
  logic                  w_rd_zero;
  logic                  w_rd_in_range;
  logic                  w_pipe_empty;
  logic [ADDR_WIDTH-1:0] w_rd_ram_addr;
  logic [ADDR_WIDTH-1:0] w_wr_ram_addr;
  logic [ADDR_WIDTH-1:0] w_bank0_addr;
  logic [ADDR_WIDTH-1:0] w_bank1_addr;
  logic                  w_bank0_we;
  logic                  w_bank1_we;
  logic [DATA_WIDTH-1:0] w_bank0_q;
  logic [DATA_WIDTH-1:0] w_bank1_q;

  rd_tag_t               r_tag [c_lat];
  logic [ADDR_WIDTH-1:0] r_num [c_lat];

  assign w_rd_acc      = rd_req && rd_ready;
  assign w_wr_acc      = wr_en && wr_ready;
  assign w_shadow_full = (r_shadow_num == ADDR_WIDTH'(PARTICLE_NUM - 1));
  assign w_wr_commit   = w_wr_acc && !w_shadow_full;
  assign w_rd_zero     = (rd_addr == '0);
  assign w_rd_in_range = ({1'b0, rd_addr} < (ADDR_WIDTH + 1)'(PARTICLE_NUM));
  // Clamp so an out-of-range address never indexes past the array.
  assign w_rd_ram_addr = w_rd_in_range ? rd_addr : '0;
  assign w_wr_ram_addr = r_shadow_num + ADDR_WIDTH'(1);

  assign w_bank0_addr  = r_bank_sel ? w_wr_ram_addr : w_rd_ram_addr;
  assign w_bank1_addr  = r_bank_sel ? w_rd_ram_addr : w_wr_ram_addr;
  assign w_bank0_we    = r_bank_sel && w_wr_commit;
  assign w_bank1_we    = !r_bank_sel && w_wr_commit;

  cell_pos_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (PARTICLE_NUM),
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_bank0 (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (w_bank0_addr),
    .we    (w_bank0_we),
    .wdata (wr_data),
    .q     (w_bank0_q)
  );

  cell_pos_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (PARTICLE_NUM),
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  ("")
  ) u_bank1 (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (w_bank1_addr),
    .we    (w_bank1_we),
    .wdata (wr_data),
    .q     (w_bank1_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_lat; i++) begin
        r_tag[i] <= '0;
        r_num[i] <= '0;
      end
    end else begin
      r_tag[0].valid    <= w_rd_acc;
      r_tag[0].zero     <= w_rd_zero;
      r_tag[0].in_range <= w_rd_in_range;
      r_tag[0].sel      <= r_bank_sel;
      r_num[0]          <= r_active_num;
      for (int i = 1; i < c_lat; i++) begin
        r_tag[i] <= r_tag[i-1];
        r_num[i] <= r_num[i-1];
      end
    end
  end

`ifdef CELL_MEM_RANGE_CHECK_EN
  logic r_oob [c_lat];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_lat; i++) begin
        r_oob[i] <= 1'b0;
      end
    end else begin
      r_oob[0] <= !w_rd_zero && (rd_addr > r_active_num);
      for (int i = 1; i < c_lat; i++) begin
        r_oob[i] <= r_oob[i-1];
      end
    end
  end

  assign rd_oob = r_tag[c_lat-1].valid && r_oob[c_lat-1];
`endif

  always_comb begin
    w_pipe_empty = 1'b1;
    for (int i = 0; i < c_lat; i++) begin
      if (r_tag[i].valid) begin
        w_pipe_empty = 1'b0;
      end
    end
  end

  assign rd_valid = r_tag[c_lat-1].valid;

  always_comb begin
    rd_data = r_tag[c_lat-1].sel ? w_bank1_q : w_bank0_q;
    if (r_tag[c_lat-1].zero) begin
      rd_data = DATA_WIDTH'(r_num[c_lat-1]);
    end else if (!r_tag[c_lat-1].in_range) begin
      rd_data = '0;
    end
`ifdef CELL_MEM_RANGE_CHECK_EN
    else if (r_oob[c_lat-1]) begin
      rd_data = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_run;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_run:   if (swap_req) w_state_nxt = c_st_drain;
      c_st_drain: if (w_pipe_empty) w_state_nxt = c_st_swap;
      c_st_swap:  w_state_nxt = c_st_run;
      default:    w_state_nxt = c_st_run;
    endcase
  end

  always_comb begin
    rd_ready = (r_state == c_st_run);
    wr_ready = (r_state == c_st_run);
    swap_ack = (r_state == c_st_swap);
  end

  // Writes are only accepted in RUN, so they never coincide with SWAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank_sel   <= 1'b0;
      r_active_num <= ADDR_WIDTH'(INIT_NUM);
      r_shadow_num <= '0;
      r_overflow   <= 1'b0;
    end else if (r_state == c_st_swap) begin
      r_bank_sel   <= !r_bank_sel;
      r_active_num <= r_shadow_num;
      r_shadow_num <= '0;
      r_overflow   <= 1'b0;
    end else if (w_wr_acc) begin
      if (w_shadow_full) begin
        r_overflow <= 1'b1;
      end else begin
        r_shadow_num <= w_wr_ram_addr;
      end
    end
  end

  assign active_num = r_active_num;
  assign shadow_num = r_shadow_num;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_cell_pos_pingpong_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_cell_pos_pingpong_mem
// Description : Randomised scoreboard bench for cell_pos_pingpong_mem.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cell_pos_pingpong_mem;
  import cell_pos_pingpong_mem_pkg::*;

  localparam int DW       = c_data_width_def;
  localparam int PN       = 20;
  localparam int AW       = 5;
  localparam int INIT_NUM = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          swap_req;
  logic          swap_ack;
  logic [AW-1:0] active_num;
  logic [AW-1:0] shadow_num;
  logic          overflow;
`ifdef CELL_MEM_RANGE_CHECK_EN
  logic          rd_oob;
`endif

  cell_pos_pingpong_mem #(
    .DATA_WIDTH   (DW),
    .PARTICLE_NUM (PN),
    .ADDR_WIDTH   (AW),
    .INIT_FILE    ("cell_ini.hex"),
    .INIT_NUM     (INIT_NUM)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .swap_req   (swap_req),
    .swap_ack   (swap_ack),
    .active_num (active_num),
    .shadow_num (shadow_num),
    .overflow   (overflow)
`ifdef CELL_MEM_RANGE_CHECK_EN
    ,
    .rd_oob     (rd_oob)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference model: two banks as plain arrays plus the counts.
  bit            m_sel;
  int            m_active;
  int            m_shadow;
  bit            m_ovf;
  logic [DW-1:0] m_mem   [2][PN];
  bit            m_known [2][PN];

  typedef struct {
    int unsigned   cyc;
    logic [DW-1:0] data;
    bit            known;
    bit            oob;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rand_pos();
    logic [c_axis_width-1:0] x, y, z;
    x = $urandom;
    y = $urandom;
    z = $urandom;
    return {z, y, x};
  endfunction

  function automatic exp_t predict(input int addr);
    exp_t e;
    e.cyc   = 0;
    e.data  = '0;
    e.known = 1'b1;
    e.oob   = 1'b0;
    if (addr == 0) begin
      e.data = DW'(m_active);
    end
`ifdef CELL_MEM_RANGE_CHECK_EN
    else if (addr > m_active) begin
      e.oob = 1'b1;
    end
`endif
    else if (addr < PN) begin
      e.data  = m_mem[m_sel][addr];
      e.known = m_known[m_sel][addr];
    end
    return e;
  endfunction

  // Present one request set for the coming edge and update the model.
  task automatic drive(input bit rd, input int addr, input bit wr, input logic [DW-1:0] d);
    exp_t e;
    rd_req  = rd;
    rd_addr = AW'(addr);
    wr_en   = wr;
    wr_data = d;
    if (rd) begin
      e = predict(addr);
      e.cyc = cyc + 2;
      exp_q.push_back(e);
    end
    if (wr) begin
      if (m_shadow == PN - 1) begin
        m_ovf = 1'b1;
      end else begin
        m_shadow++;
        m_mem[m_sel ^ 1'b1][m_shadow]   = d;
        m_known[m_sel ^ 1'b1][m_shadow] = 1'b1;
      end
    end
  endtask

  task automatic step(input bit rd, input int addr, input bit wr, input logic [DW-1:0] d);
    drive(rd, addr, wr, d);
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    wr_en  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_active_num"}, active_num, m_active);
    chk({tag, "_shadow_num"}, shadow_num, m_shadow);
    chk({tag, "_overflow"},   overflow,   m_ovf);
    chk({tag, "_rd_ready"},   rd_ready,   1);
    chk({tag, "_wr_ready"},   wr_ready,   1);
    chk({tag, "_swap_ack"},   swap_ack,   0);
  endtask

  task automatic do_swap(input bit rd, input int addr, input bit wr, input logic [DW-1:0] d);
    bit got = 1'b0;
    swap_req = 1'b1;
    drive(rd, addr, wr, d);
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    wr_en  = 1'b0;
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk);
      if (swap_ack) begin
        got = 1'b1;
        chk("swap_after_drain", exp_q.size(), 0);
      end else begin
        chk("drain_rd_ready", rd_ready, 0);
        chk("drain_wr_ready", wr_ready, 0);
      end
      @(posedge clk);
      #1;
    end
    swap_req = 1'b0;
    if (got) begin
      m_sel    = m_sel ^ 1'b1;
      m_active = m_shadow;
      m_shadow = 0;
      m_ovf    = 1'b0;
    end else begin
      checks++;
      errors++;
      $display("FAIL swap_ack_timeout: got no ack expected ack within 16 cycles");
    end
  endtask

  task automatic do_reset();
    swap_req = 1'b0;
    rd_req   = 1'b0;
    wr_en    = 1'b0;
    rst_n    = 1'b0;
    exp_q.delete();
    m_sel    = 1'b0;
    m_active = INIT_NUM;
    m_shadow = 0;
    m_ovf    = 1'b0;
    #1;
    chk("reset_rd_valid", rd_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every rd_valid must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rd_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rd_valid: got rd_valid=1 expected none (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("rd_latency", cyc, e.cyc);
          if (e.known) chk("rd_data", rd_data, e.data);
`ifdef CELL_MEM_RANGE_CHECK_EN
          chk("rd_oob", rd_oob, e.oob);
`endif
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < PN; a++) begin
        m_known[b][a] = 1'b0;
        m_mem[b][a]   = '0;
      end
    end
    rd_addr = '0;
    wr_data = '0;
    do_reset();

    chk("reset_rd_data", rd_data, 0);
    check_status("reset");

    // Count word, an init-bank word, back-to-back reads, past-depth address.
    step(1, 0, 0, '0);
    step(1, 3, 0, '0);
    step(1, 1, 0, '0);
    step(1, 2, 0, '0);
    step(1, 3, 0, '0);
    step(1, 25, 0, '0);
    idle(3);

    // Fill four words, swap, read them back from the new active bank.
    for (int i = 0; i < 4; i++) step(0, 0, 1, DW'(10 + i));
    check_status("fill4");
    do_swap(0, 0, 0, '0);
    check_status("swap1");
    for (int a = 1; a <= 4; a++) step(1, a, 0, '0);
    step(1, 0, 0, '0);
    step(1, 7, 0, '0);
    idle(3);

    // Read and write accepted in the same cycle as swap_req.
    do_swap(1, 2, 1, rand_pos());
    check_status("swap2");

    // Randomised mix of reads, writes and swaps.
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 99) < 5) begin
        do_swap($urandom_range(0, 1) == 1, $urandom_range(0, 31),
                $urandom_range(0, 1) == 1, rand_pos());
      end else begin
        step($urandom_range(0, 1) == 1, $urandom_range(0, 31),
             $urandom_range(0, 2) == 0, rand_pos());
      end
      if (it % 25 == 0) check_status("rand");
    end
    idle(3);

    // Overflow: PN writes into an empty shadow bank, the last is dropped.
    do_swap(0, 0, 0, '0);
    for (int i = 0; i < PN; i++) step(0, 0, 1, rand_pos());
    chk("ovf_flag", overflow, 1);
    chk("ovf_shadow_num", shadow_num, PN - 1);
    check_status("ovf");
    do_swap(0, 0, 0, '0);
    chk("ovf_cleared", overflow, 0);
    check_status("ovf_swap");
    step(1, 0, 0, '0);
    step(1, 1, 0, '0);
    step(1, PN - 1, 0, '0);
    idle(3);

    // Reset during DRAIN with a read in flight.
    swap_req = 1'b1;
    drive(1, 2, 0, '0);
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    do_reset();
    idle(4);
    check_status("mid_reset");
    for (int a = 1; a <= 3; a++) step(1, a, 0, '0);
    step(1, 0, 0, '0);
    idle(4);

    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
